// File: rtl/motion_pkg.sv
// Shared types for the motion detector: FSM state encoding and
// counter width helper derived from the frame size.
package motion_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  function automatic int cnt_width(input int pixels);
    return $clog2(pixels + 1);
  endfunction

endpackage

// File: rtl/result_hold.sv
// Holds a published result under a valid/ack handshake and flags overruns.
// Ports: publish/data_in load a result; ack consumes it; clear drops overrun.
module result_hold #(
  parameter int W = 8
)(
  input  logic         clk,
  input  logic         reset,
  input  logic         publish,
  input  logic [W-1:0] data_in,
  input  logic         ack,
  input  logic         clear,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         overrun
);

  // A result still pending and not consumed this cycle gets overwritten.
  logic lost;
  assign lost = publish && valid && !ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid   <= 1'b0;
      data    <= '0;
      overrun <= 1'b0;
    end else begin
      if (publish) begin
        valid <= 1'b1;
        data  <= data_in;
      end else if (ack) begin
        valid <= 1'b0;
      end
      if (lost) begin
        overrun <= 1'b1;
      end else if (clear) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/motion_detector.sv
// Counts changed pixels per frame and publishes count and motion verdict.
// Ports: frame_start/valid_data/frame_difference in; result handshake out.
module motion_detector
  import motion_pkg::*;
#(
  parameter  int FRAME_PIXELS  = 76800,
  parameter  int MOTION_THRESH = 2000,
  localparam int CNT_W         = cnt_width(FRAME_PIXELS)
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             frame_difference,
  input  logic             valid_data,
  output logic             result_valid,
  input  logic             result_ack,
  output logic [CNT_W-1:0] change_count,
  output logic             motion_detected,
  output logic             busy,
  output logic             short_frame,
  output logic             sync_err,
  output logic             overrun,
  input  logic             clear_err
);

  state_t           state, state_n;
  logic [CNT_W-1:0] pix_cnt, pix_n;
  logic [CNT_W-1:0] chg_acc, acc_n;
  logic [CNT_W-1:0] diff_ext;
  logic [CNT_W-1:0] sum;
  logic             last_beat;
  logic             motion_now;
  logic             publish;
  logic             short_set;
  logic             sync_set;

  assign diff_ext   = {{(CNT_W-1){1'b0}}, frame_difference};
  assign sum        = chg_acc + diff_ext;
  assign last_beat  = (pix_cnt == CNT_W'(FRAME_PIXELS - 1));
  assign motion_now = (sum >= CNT_W'(MOTION_THRESH));
  assign busy       = (state == ACCUM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pix_cnt <= '0;
      chg_acc <= '0;
    end else begin
      state   <= state_n;
      pix_cnt <= pix_n;
      chg_acc <= acc_n;
    end
  end

  always_comb begin
    state_n   = state;
    pix_n     = pix_cnt;
    acc_n     = chg_acc;
    publish   = 1'b0;
    short_set = 1'b0;
    sync_set  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          // A coincident beat is pixel 0 of the new frame.
          state_n = ACCUM;
          pix_n   = valid_data ? CNT_W'(1) : '0;
          acc_n   = valid_data ? diff_ext : '0;
        end else if (valid_data) begin
          sync_set = 1'b1;
        end
      end
      ACCUM: begin
        if (frame_start) begin
          // Abort: partial count is dropped, never published.
          short_set = 1'b1;
          pix_n     = valid_data ? CNT_W'(1) : '0;
          acc_n     = valid_data ? diff_ext : '0;
        end else if (valid_data) begin
          if (last_beat) begin
            publish = 1'b1;
            state_n = IDLE;
            pix_n   = '0;
            acc_n   = '0;
          end else begin
            pix_n = pix_cnt + CNT_W'(1);
            acc_n = sum;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Sticky error flags: a set event beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      short_frame <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      if (short_set) begin
        short_frame <= 1'b1;
      end else if (clear_err) begin
        short_frame <= 1'b0;
      end
      if (sync_set) begin
        sync_err <= 1'b1;
      end else if (clear_err) begin
        sync_err <= 1'b0;
      end
    end
  end

  logic [CNT_W:0] res_q;

  result_hold #(
    .W(CNT_W + 1)
  ) u_hold (
    .clk    (clk),
    .reset  (reset),
    .publish(publish),
    .data_in({motion_now, sum}),
    .ack    (result_ack),
    .clear  (clear_err),
    .valid  (result_valid),
    .data   (res_q),
    .overrun(overrun)
  );

  assign motion_detected = res_q[CNT_W];
  assign change_count    = res_q[CNT_W-1:0];

endmodule

// File: tb/tb_motion_detector.sv
// Scoreboard bench for motion_detector with a 16-pixel frame, threshold 4.
// Expected frame results are queued at the last beat and popped at publish.
module tb_motion_detector;

  localparam int FP = 16;
  localparam int TH = 4;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_start = 1'b0;
  logic          frame_difference = 1'b0;
  logic          valid_data = 1'b0;
  logic          result_ack = 1'b0;
  logic          clear_err = 1'b0;
  logic          result_valid;
  logic [CW-1:0] change_count;
  logic          motion_detected;
  logic          busy;
  logic          short_frame;
  logic          sync_err;
  logic          overrun;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          mot;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  motion_detector #(
    .FRAME_PIXELS (FP),
    .MOTION_THRESH(TH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .frame_start     (frame_start),
    .frame_difference(frame_difference),
    .valid_data      (valid_data),
    .result_valid    (result_valid),
    .result_ack      (result_ack),
    .change_count    (change_count),
    .motion_detected (motion_detected),
    .busy            (busy),
    .short_frame     (short_frame),
    .sync_err        (sync_err),
    .overrun         (overrun),
    .clear_err       (clear_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rv"}, 32'(result_valid), 0);
    chk({tag, "_cnt"}, 32'(change_count), 0);
    chk({tag, "_mot"}, 32'(motion_detected), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_short"}, 32'(short_frame), 0);
    chk({tag, "_sync"}, 32'(sync_err), 0);
    chk({tag, "_ovr"}, 32'(overrun), 0);
  endtask

  task automatic run_frame(input logic [15:0] d,
                           input int maxgap,
                           input bit ack_last);
    exp_t e;
    for (int i = 0; i < FP; i++) begin
      if (i > 0) repeat ($urandom_range(maxgap, 0)) tick();
      frame_start      = (i == 0);
      valid_data       = 1'b1;
      frame_difference = d[i];
      result_ack       = ack_last && (i == FP - 1);
      if (i == FP - 1) begin
        e.cnt = CW'($countones(d));
        e.mot = ($countones(d) >= TH);
        sb.push_back(e);
      end
      tick();
      frame_start      = 1'b0;
      valid_data       = 1'b0;
      frame_difference = 1'b0;
      result_ack       = 1'b0;
    end
  endtask

  task automatic check_pub(input string tag);
    exp_t e;
    @(negedge clk);
    chk({tag, "_q"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_cnt"}, 32'(change_count), 32'(e.cnt));
      chk({tag, "_mot"}, 32'(motion_detected), 32'(e.mot));
    end
    chk({tag, "_rv"}, 32'(result_valid), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic ack_clear(input bit clr);
    result_ack = 1'b1;
    clear_err  = clr;
    tick();
    result_ack = 1'b0;
    clear_err  = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1 chk_zero("rst");
    tick();
    tick();
    reset = 1'b0;

    run_frame(16'h8421, 0, 1'b0);
    check_pub("f4");
    ack_clear(1'b0);

    run_frame(16'h0111, 3, 1'b0);
    check_pub("f3");
    ack_clear(1'b0);
    @(negedge clk);
    chk("ack_rv", 32'(result_valid), 0);
    chk("ack_cnt", 32'(change_count), 3);

    for (int i = 0; i < 7; i++) begin
      frame_start      = (i == 0);
      valid_data       = 1'b1;
      frame_difference = (i == 0 || i == 5);
      tick();
      frame_start      = 1'b0;
      valid_data       = 1'b0;
      frame_difference = 1'b0;
    end
    @(negedge clk);
    chk("part_busy", 32'(busy), 1);
    chk("part_rv", 32'(result_valid), 0);
    chk("part_short", 32'(short_frame), 0);
    run_frame(16'h001F, 1, 1'b0);
    check_pub("abort");
    chk("abort_short", 32'(short_frame), 1);
    ack_clear(1'b1);
    @(negedge clk);
    chk("clr_short", 32'(short_frame), 0);
    chk("clr_rv", 32'(result_valid), 0);

    run_frame(16'h00FF, 1, 1'b0);
    check_pub("ovA");
    chk("ovA_ovr", 32'(overrun), 0);
    run_frame(16'h0003, 2, 1'b0);
    check_pub("ovB");
    chk("ovB_ovr", 32'(overrun), 1);
    ack_clear(1'b1);
    @(negedge clk);
    chk("ovclr", 32'(overrun), 0);
    run_frame(16'h0F00, 0, 1'b0);
    check_pub("ackA");
    run_frame(16'h1000, 0, 1'b1);
    check_pub("ackB");
    chk("ackB_ovr", 32'(overrun), 0);
    ack_clear(1'b0);

    valid_data       = 1'b1;
    frame_difference = 1'b1;
    repeat (3) tick();
    valid_data       = 1'b0;
    frame_difference = 1'b0;
    @(negedge clk);
    chk("sync_set", 32'(sync_err), 1);
    chk("sync_busy", 32'(busy), 0);
    chk("sync_rv", 32'(result_valid), 0);
    run_frame(16'hFFFF, 1, 1'b0);
    check_pub("full");
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    @(negedge clk);
    chk("sync_clr", 32'(sync_err), 0);

    for (int i = 0; i < 9; i++) begin
      frame_start      = (i == 0);
      valid_data       = 1'b1;
      frame_difference = 1'b1;
      tick();
      frame_start      = 1'b0;
      valid_data       = 1'b0;
      frame_difference = 1'b0;
    end
    #2 reset = 1'b1;
    #1 chk_zero("midrst");
    tick();
    reset = 1'b0;
    run_frame(16'h0006, 0, 1'b0);
    check_pub("post");
    chk("post_ovr", 32'(overrun), 0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
